// File: rtl/uart_conv_encode_bridge.sv
// Collects NUM_BYTES UART bytes, rate-1/2 convolutionally encodes them with run-time
// constraint length and generators (optional zero tail), then streams the code bytes out.
module uart_conv_encode_bridge #(
   parameter int NUM_BYTES = 4,
   parameter int K_MAX     = 7,
   parameter int TAIL_EN   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic [3:0]       k_sel,
   input  logic [K_MAX-1:0] g0,
   input  logic [K_MAX-1:0] g1,
   input  logic             abort,
   input  logic             tx_busy,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   output logic             busy,
   output logic             done,
   output logic             rx_overrun,
   output logic [7:0]       tx_count
);
   localparam int PAY_W     = 8 * NUM_BYTES;
   localparam int OUT_BYTES = (16 * NUM_BYTES + 2 * (K_MAX - 1) + 7) / 8;
   localparam int OUT_W     = 8 * OUT_BYTES;
   localparam int LEN_MAX   = PAY_W + K_MAX - 1;
   localparam int CW        = $clog2(LEN_MAX + 4);
   localparam int SW        = $clog2(NUM_BYTES + 1);
   localparam int BW        = $clog2(OUT_BYTES + 1);

   localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_BYTES - 1);
   localparam logic [CW-1:0] PAY_BITS  = CW'(PAY_W);
   localparam logic [3:0]    K_MAX_C   = 4'(K_MAX);

   typedef enum logic [1:0] {COLLECT, ENCODE, ISSUE, GUARD} state_t;

   state_t             state_q, state_d;
   logic [PAY_W-1:0]   payBuf_q, payBuf_d;
   logic [SW-1:0]      slot_q, slot_d;
   logic [K_MAX-2:0]   sr_q, sr_d;
   logic [K_MAX-1:0]   mask_q, mask_d;
   logic [CW-1:0]      bitCnt_q, bitCnt_d;
   logic [CW-1:0]      len_q, len_d;
   logic [BW-1:0]      nBytes_q, nBytes_d;
   logic [BW-1:0]      byteIdx_q, byteIdx_d;
   logic [OUT_W-1:0]   outBuf_q, outBuf_d;
   logic [7:0]         txData_q, txData_d;
   logic [7:0]         txCount_q, txCount_d;
   logic               done_q, done_d;
   logic               overrun_q, overrun_d;

   logic [3:0]         kEff;
   logic [CW-1:0]      lenNew;
   logic               inBit;
   logic [K_MAX-1:0]   w;
   logic               c0, c1;
   logic [7:0]         curByte;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state_q   <= COLLECT;
         payBuf_q  <= '0;
         slot_q    <= '0;
         sr_q      <= '0;
         mask_q    <= '0;
         bitCnt_q  <= '0;
         len_q     <= '0;
         nBytes_q  <= '0;
         byteIdx_q <= '0;
         outBuf_q  <= '0;
         txData_q  <= '0;
         txCount_q <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         payBuf_q  <= payBuf_d;
         slot_q    <= slot_d;
         sr_q      <= sr_d;
         mask_q    <= mask_d;
         bitCnt_q  <= bitCnt_d;
         len_q     <= len_d;
         nBytes_q  <= nBytes_d;
         byteIdx_q <= byteIdx_d;
         outBuf_q  <= outBuf_d;
         txData_q  <= txData_d;
         txCount_q <= txCount_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   // Bits past the payload fall off the shift and read as 0, which supplies the tail.
   always_comb begin
      kEff = k_sel;
      if (k_sel < 4'd3) begin
         kEff = 4'd3;
      end else if (k_sel > K_MAX_C) begin
         kEff = K_MAX_C;
      end
      lenNew  = PAY_BITS + ((TAIL_EN != 0) ? (CW'(kEff) - CW'(1)) : CW'(0));
      inBit   = |(payBuf_q & (PAY_W'(1) << bitCnt_q));
      w       = {sr_q, inBit};
      c0      = ^(w & g0 & mask_q);
      c1      = ^(w & g1 & mask_q);
      curByte = 8'(outBuf_q >> {byteIdx_q, 3'b000});
   end

   always_comb begin
      state_d   = state_q;
      payBuf_d  = payBuf_q;
      slot_d    = slot_q;
      sr_d      = sr_q;
      mask_d    = mask_q;
      bitCnt_d  = bitCnt_q;
      len_d     = len_q;
      nBytes_d  = nBytes_q;
      byteIdx_d = byteIdx_q;
      outBuf_d  = outBuf_q;
      txData_d  = txData_q;
      txCount_d = txCount_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      tx_start  = 1'b0;

      if (rx_valid && (state_q != COLLECT)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         COLLECT: begin
            if (rx_valid) begin
               payBuf_d  = payBuf_q | (PAY_W'(rx_data) << {slot_q, 3'b000});
               slot_d    = slot_q + SW'(1);
               txCount_d = '0;
               if (slot_q == LAST_SLOT) begin
                  state_d  = ENCODE;
                  slot_d   = '0;
                  mask_d   = ~({K_MAX{1'b1}} << kEff);
                  len_d    = lenNew;
                  nBytes_d = BW'((lenNew + CW'(3)) >> 2);
                  sr_d     = '0;
                  bitCnt_d = '0;
                  outBuf_d = '0;
               end
            end
         end
         ENCODE: begin
            outBuf_d = outBuf_q | (OUT_W'({c1, c0}) << {bitCnt_q, 1'b0});
            sr_d     = w[K_MAX-2:0];
            bitCnt_d = bitCnt_q + CW'(1);
            if (bitCnt_q == len_q - CW'(1)) begin
               state_d   = ISSUE;
               byteIdx_d = '0;
            end
         end
         ISSUE: begin
            if (!tx_busy) begin
               tx_start  = 1'b1;
               txData_d  = curByte;
               txCount_d = 8'(byteIdx_q) + 8'd1;
               state_d   = GUARD;
            end
         end
         GUARD: begin
            if (byteIdx_q == nBytes_q - BW'(1)) begin
               state_d  = COLLECT;
               done_d   = 1'b1;
               payBuf_d = '0;
            end else begin
               byteIdx_d = byteIdx_q + BW'(1);
               state_d   = ISSUE;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   assign tx_data    = tx_start ? curByte : txData_q;
   assign busy       = (state_q != COLLECT);
   assign done       = done_q;
   assign rx_overrun = overrun_q;
   assign tx_count   = txCount_q;

endmodule
